// File: rtl/ram_inspector.sv
// ram_inspector: memory inspection sequencer for the 16-byte CPU RAM.
//
// While enabled, the sequencer takes over the RAM read address. For each location it
// waits SETTLE_CYCLES for read data to settle and then captures an address/data pair.
// It holds that location until an advance event, then moves on to the next address.
// Advance events are either a step rising edge (manual mode) or DWELL_CYCLES elapsing
// (auto mode). All outputs are registered.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   enable       inspection mode request (level)
//   step         debounced advance request; only the rising edge matters
//   auto         1 = advance every DWELL_CYCLES, 0 = advance on step
//   ram_data     combinational RAM read data for addr
//   addr         RAM read address
//   addr_valid   addr overrides the MAR address into RAM
//   busy         high while settling or capturing
//   sample_valid one-cycle pulse when sample_addr/sample_data update
//   sample_addr  address of the last captured byte
//   sample_data  last captured byte
//   wrap         one-cycle pulse when addr advances from the last location to 0
module ram_inspector #(
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned DWELL_CYCLES  = 27_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  step,
  input  logic                  auto,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  addr_valid,
  output logic                  busy,
  output logic                  sample_valid,
  output logic [ADDR_WIDTH-1:0] sample_addr,
  output logic [DATA_WIDTH-1:0] sample_data,
  output logic                  wrap
);

  localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned DwellW  = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);
  localparam logic [DwellW-1:0]  DwellLast  = DwellW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StCapture, StHold} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    addr_valid_q;
  logic                    busy_q;
  logic                    sample_valid_q;
  logic [ADDR_WIDTH-1:0]   sample_addr_q;
  logic [DATA_WIDTH-1:0]   sample_data_q;
  logic                    wrap_q;
  logic [SettleW-1:0]      settle_q;
  logic [DwellW-1:0]       dwell_q;
  logic                    step_q;

  logic step_rise;
  assign step_rise = step & ~step_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      addr_q         <= '0;
      addr_valid_q   <= 1'b0;
      busy_q         <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_addr_q  <= '0;
      sample_data_q  <= '0;
      wrap_q         <= 1'b0;
      settle_q       <= '0;
      dwell_q        <= '0;
      step_q         <= 1'b0;
    end else begin
      // The edge register always tracks step, so edges seen outside HOLD are consumed.
      step_q         <= step;
      sample_valid_q <= 1'b0;
      wrap_q         <= 1'b0;

      if (!enable) begin
        // Abandon whatever is in flight; captured sample_* values are kept.
        state_q      <= StIdle;
        addr_valid_q <= 1'b0;
        busy_q       <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            addr_q       <= '0;
            settle_q     <= '0;
            addr_valid_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= StSettle;
          end
          StSettle: begin
            settle_q <= settle_q + SettleW'(1);
            if (settle_q == SettleLast) begin
              state_q <= StCapture;
            end
          end
          StCapture: begin
            sample_addr_q  <= addr_q;
            sample_data_q  <= ram_data;
            sample_valid_q <= 1'b1;
            dwell_q        <= '0;
            busy_q         <= 1'b0;
            state_q        <= StHold;
          end
          StHold: begin
            // Dwell only counts in auto mode; leaving auto clears it so the next
            // auto period starts from a full dwell.
            if ((auto && (dwell_q == DwellLast)) || (!auto && step_rise)) begin
              addr_q   <= addr_q + ADDR_WIDTH'(1);
              wrap_q   <= &addr_q;
              settle_q <= '0;
              dwell_q  <= '0;
              busy_q   <= 1'b1;
              state_q  <= StSettle;
            end else if (auto) begin
              dwell_q <= dwell_q + DwellW'(1);
            end else begin
              dwell_q <= '0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign addr         = addr_q;
  assign addr_valid   = addr_valid_q;
  assign busy         = busy_q;
  assign sample_valid = sample_valid_q;
  assign sample_addr  = sample_addr_q;
  assign sample_data  = sample_data_q;
  assign wrap         = wrap_q;

endmodule

// File: tb/tb_ram_inspector.sv
// tb_ram_inspector: scoreboard bench for ram_inspector (SETTLE_CYCLES=2, DWELL_CYCLES=5).
// Stimulus pushes the expected sample (address, data, cycle of the sample_valid pulse)
// into a queue; a monitor pops and compares on every sample_valid.
module tb_ram_inspector;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       step;
  logic       auto;
  logic [7:0] ram_data;
  logic [3:0] addr;
  logic       addr_valid;
  logic       busy;
  logic       sample_valid;
  logic [3:0] sample_addr;
  logic [7:0] sample_data;
  logic       wrap;

  logic [7:0] mem [16];
  assign ram_data = mem[addr];

  ram_inspector #(
    .ADDR_WIDTH   (4),
    .DATA_WIDTH   (8),
    .SETTLE_CYCLES(2),
    .DWELL_CYCLES (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .step        (step),
    .auto        (auto),
    .ram_data    (ram_data),
    .addr        (addr),
    .addr_valid  (addr_valid),
    .busy        (busy),
    .sample_valid(sample_valid),
    .sample_addr (sample_addr),
    .sample_data (sample_data),
    .wrap        (wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Number of rising edges seen so far.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned wrap_cnt = 0;

  typedef struct {
    int unsigned a;
    int unsigned d;
    int unsigned c;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input int unsigned a, input int unsigned d, input int unsigned c);
    exp_t e;
    e.a = a;
    e.d = d;
    e.c = c;
    sbq.push_back(e);
  endtask

  task automatic goto(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: every sample_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (sample_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("sample_spurious", {31'b0, sample_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sample_addr", {28'b0, sample_addr}, e.a);
        chk("sample_data", {24'b0, sample_data}, e.d);
        chk("sample_cycle", cyc, e.c);
      end
    end
    if (wrap === 1'b1) begin
      wrap_cnt++;
      chk("wrap_addr", {28'b0, addr}, 32'd0);
    end
  end

  initial begin
    repeat (3000) @(posedge clk);
    $display("FAIL watchdog: run did not finish within 3000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 17);
    mem[0] = 8'h1E;
    rst    = 1'b1;
    enable = 1'b1;
    step   = 1'b0;
    auto   = 1'b0;

    // Reset with enable already high.
    goto(2);
    chk("rst_addr", {28'b0, addr}, 32'd0);
    chk("rst_addr_valid", {31'b0, addr_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_sample_valid", {31'b0, sample_valid}, 32'd0);
    chk("rst_sample_addr", {28'b0, sample_addr}, 32'd0);
    chk("rst_sample_data", {24'b0, sample_data}, 32'd0);
    chk("rst_wrap", {31'b0, wrap}, 32'd0);
    c = cyc;
    rst = 1'b0;
    push(0, 8'h1E, c + 4);
    goto(c + 1);
    chk("entry_addr_valid", {31'b0, addr_valid}, 32'd1);
    chk("entry_busy", {31'b0, busy}, 32'd1);
    chk("entry_addr", {28'b0, addr}, 32'd0);
    goto(c + 4);
    chk("hold_busy", {31'b0, busy}, 32'd0);
    goto(c + 5);
    mem[0] = 8'h00;

    // Manual scan across all 16 locations, wrapping back to 0.
    for (int i = 1; i <= 16; i++) begin
      c = cyc;
      step = 1'b1;
      push(i % 16, ((i % 16) * 17) & 8'hFF, c + 4);
      goto(c + 1);
      chk("step_addr", {28'b0, addr}, i % 16);
      chk("step_wrap", {31'b0, wrap}, (i == 16) ? 32'd1 : 32'd0);
      step = 1'b0;
      goto(c + 5);
    end

    // Edge during SETTLE is dropped; a held level advances only once.
    c = cyc;
    step = 1'b1;
    push(1, 8'h11, c + 4);
    goto(c + 1);
    step = 1'b0;
    goto(c + 2);
    step = 1'b1;
    goto(c + 102);
    chk("held_step_addr", {28'b0, addr}, 32'd1);
    step = 1'b0;
    goto(c + 106);
    chk("after_held_addr", {28'b0, addr}, 32'd1);

    // Auto mode: one sample every 8 cycles; step ignored; auto toggle restarts dwell.
    c = cyc;
    auto = 1'b1;
    push(2, 8'h22, c + 8);
    push(3, 8'h33, c + 16);
    push(4, 8'h44, c + 24);
    goto(c + 10);
    step = 1'b1;
    goto(c + 12);
    step = 1'b0;
    goto(c + 26);
    auto = 1'b0;
    goto(c + 27);
    auto = 1'b1;
    push(5, 8'h55, c + 35);
    push(6, 8'h66, c + 43);
    goto(c + 43);
    auto = 1'b0;
    goto(c + 50);
    chk("auto_off_addr", {28'b0, addr}, 32'd6);

    // Drop enable while settling at address 7.
    c = cyc;
    step = 1'b1;
    goto(c + 1);
    chk("pre_drop_addr", {28'b0, addr}, 32'd7);
    step = 1'b0;
    enable = 1'b0;
    goto(c + 2);
    chk("drop_addr_valid", {31'b0, addr_valid}, 32'd0);
    chk("drop_busy", {31'b0, busy}, 32'd0);
    chk("drop_sample_addr", {28'b0, sample_addr}, 32'd6);
    chk("drop_sample_data", {24'b0, sample_data}, 32'h66);
    goto(c + 8);
    c = cyc;
    enable = 1'b1;
    push(0, 8'h00, c + 4);
    goto(c + 5);

    // Walk to address 9, then reset while holding.
    for (int i = 1; i <= 9; i++) begin
      c = cyc;
      step = 1'b1;
      push(i, (i * 17) & 8'hFF, c + 4);
      goto(c + 1);
      step = 1'b0;
      goto(c + 5);
    end
    chk("pre_rst_addr", {28'b0, addr}, 32'd9);
    c = cyc;
    rst = 1'b1;
    goto(c + 1);
    chk("hold_rst_addr", {28'b0, addr}, 32'd0);
    chk("hold_rst_addr_valid", {31'b0, addr_valid}, 32'd0);
    chk("hold_rst_busy", {31'b0, busy}, 32'd0);
    chk("hold_rst_sample_addr", {28'b0, sample_addr}, 32'd0);
    chk("hold_rst_sample_data", {24'b0, sample_data}, 32'd0);
    chk("hold_rst_wrap", {31'b0, wrap}, 32'd0);
    enable = 1'b0;
    rst = 1'b0;
    goto(c + 5);
    chk("idle_addr_valid", {31'b0, addr_valid}, 32'd0);

    chk("sb_empty", sbq.size(), 32'd0);
    chk("wrap_count", wrap_cnt, 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_inspector.md
# ram_inspector

Memory inspection sequencer for the 8-bit CPU's 16-byte RAM. While the CPU clock is stopped, it walks RAM addresses, reads each byte back, and hands a registered address/data pair to the display path. It is the read-back counterpart of the switch-driven RAM programming path: programming writes bytes in, and this block reads them out. It takes over the RAM address while enabled and runs entirely on the system clock.

## Interface
Parameters:
- ADDR_WIDTH, 4, RAM address width (16 locations)
- DATA_WIDTH, 8, RAM word width
- SETTLE_CYCLES, 2, cycles the address is held before sampling; must be ≥1
- DWELL_CYCLES, 27_000_000, auto-scan hold time per location (1 s at 27 MHz); must be ≥1

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- enable  in  1  inspection mode request; synchronous, level
- step  in  1  advance request; already debounced and synchronous; acts on rising edge only
- auto  in  1  1 = advance every DWELL_CYCLES; 0 = advance on step
- ram_data  in  DATA_WIDTH  combinational RAM read data for addr
- addr  out  ADDR_WIDTH  RAM read address
- addr_valid  out  1  1 = addr overrides the MAR address into RAM
- busy  out  1  1 in SETTLE or CAPTURE
- sample_valid  out  1  one-cycle pulse when sample_* update
- sample_addr  out  ADDR_WIDTH  address of last captured byte
- sample_data  out  DATA_WIDTH  last captured byte
- wrap  out  1  one-cycle pulse when addr advances from 15 to 0

## Operation
- States: IDLE, SETTLE, CAPTURE, HOLD. State update and all outputs are registered.
- Reset: state IDLE. addr, sample_addr, sample_data, settle counter, dwell counter and step edge register all 0. addr_valid, busy, sample_valid and wrap all 0.
- IDLE:
  - addr_valid=0.
  - If enable=1: addr←0, settle counter←0, go to SETTLE. This also applies when enable is already high as reset deasserts.
- SETTLE:
  - addr_valid=1, busy=1.
  - The counter increments each cycle. On the cycle it equals SETTLE_CYCLES-1, go to CAPTURE.
- CAPTURE (1 cycle):
  - sample_addr←addr, sample_data←ram_data, sample_valid=1 on the following cycle.
  - Dwell counter←0. Go to HOLD.
- HOLD:
  - addr_valid=1, busy=0.
  - Advance event when auto=1: dwell counter reaches DWELL_CYCLES-1.
  - Advance event when auto=0: step rising edge (step=1 and registered previous step=0).
  - On an advance event: addr←addr+1 modulo 16, wrap pulses when the old addr was 15, settle counter←0, go to SETTLE.
- The dwell counter runs only in HOLD with auto=1. It clears when auto=0, so re-enabling auto restarts the full dwell.
- Step edges seen in SETTLE or CAPTURE are discarded, not queued. The edge register still tracks step, so a level held across these states does not produce a later edge.
- In auto mode, step is ignored.
- enable=0 in any state: next state is IDLE, addr_valid=0, and any in-progress capture is abandoned (no sample_valid). sample_addr and sample_data hold their values. Re-enable restarts at address 0.
- rst has priority over every other input.

## Timing
- Let E be the clock edge that registers a step rising edge in HOLD. Then:
  - At E, addr shows the new address.
  - At E+SETTLE_CYCLES+1, sample_* update and sample_valid is high for the one cycle that follows.
  - The next advance is accepted no earlier than E+SETTLE_CYCLES+2.
- From enable rising (sampled at edge E0) to the first sample_valid: E0+SETTLE_CYCLES+1. The first address read is 0.
- Auto period from one sample_valid to the next: DWELL_CYCLES+SETTLE_CYCLES+1 cycles.
- wrap is asserted in the same cycle that addr becomes 0 after an advance. It is not asserted on an enable-entry reset to 0.
- ram_data must be stable within SETTLE_CYCLES cycles of an addr change.

## Test plan
- Reset with enable=1, RAM[0]=0x1E, SETTLE_CYCLES=2 → addr_valid=1 one cycle after rst drops; sample_valid pulses with sample_addr=0, sample_data=0x1E exactly 3 edges after the first enabled edge; all outputs 0 during reset.
- Manual scan, RAM[n]=n·0x11: 16 step pulses → sample_data sequence 0x11…0xFF, then 0x00 at address 0; wrap pulses once on the 15→0 advance; exactly one sample_valid per step.
- Step pulse arriving during SETTLE, plus step held high for 100 cycles → only one advance per rising edge; the mid-SETTLE edge is dropped; addr increments by exactly 1.
- Auto mode with DWELL_CYCLES=5 → sample_valid every 8 cycles; addresses 0,1,2,…; toggling auto 1→0→1 in HOLD restarts the 5-cycle dwell; step pulses while auto=1 have no effect.
- enable dropped in SETTLE at addr 7 → next cycle IDLE, addr_valid=0, no sample_valid, sample_* keep the address-6 values; re-enable → capture of address 0.
- rst asserted in HOLD at addr 9 → next edge: all outputs and addr are 0, state IDLE, no wrap pulse.
